// File: rtl/add4_rr_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder among
// NREQ requesters and returns a registered, requester-tagged sum/carry.
module add4_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_sum,
    output logic                  resp_cout
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic           slot_free;
    int unsigned    scan_idx;

    assign slot_free = !resp_valid || resp_ready;

    // Scan ptr, ptr+1, ... modulo NREQ; reset forces the grant off so nothing
    // can be accepted while the block is being cleared.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(ptr) + k) % NREQ;
            if (!grant_found && slot_free && !reset && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(scan_idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_found && grant_idx == IDW'(i)) begin
                req_ready[i] = 1'b1;
                add_a        = req_a[i*WIDTH +: WIDTH];
                add_b        = req_b[i*WIDTH +: WIDTH];
                add_cin      = req_cin[i];
            end
        end
    end

    always_comb begin
        if (int'(grant_idx) == NREQ - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + IDW'(1);
        end
    end

    // A new transfer takes priority over a drain, so accept-and-drain in the
    // same cycle keeps resp_valid high with the fresh result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_sum   <= '0;
            resp_cout  <= 1'b0;
            ptr        <= '0;
        end else if (grant_found) begin
            resp_valid <= 1'b1;
            resp_id    <= grant_idx;
            resp_sum   <= add_sum;
            resp_cout  <= add_cout;
            ptr        <= ptr_next;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add4_rr_arbiter.sv
// Directed bench for add4_rr_arbiter; the shared 4-bit adder is modelled here
// as the enclosing module would provide it.
module tb_add4_rr_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_cin;
    logic [3:0]  req_ready;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic        add_cout;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [3:0]  resp_sum;
    logic        resp_cout;

    int checks;
    int failures;

    logic [3:0] rr_sum  [4];
    logic       rr_cout [4];

    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    add4_rr_arbiter #(.NREQ(4), .WIDTH(4), .IDW(2)) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_a(req_a),
        .req_b(req_b),
        .req_cin(req_cin),
        .req_ready(req_ready),
        .add_a(add_a),
        .add_b(add_b),
        .add_cin(add_cin),
        .add_sum(add_sum),
        .add_cout(add_cout),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id(resp_id),
        .resp_sum(resp_sum),
        .resp_cout(resp_cout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rr_sum[0]  = 4'd3;  rr_cout[0] = 1'b0;
        rr_sum[1]  = 4'd8;  rr_cout[1] = 1'b0;
        rr_sum[2]  = 4'd11; rr_cout[2] = 1'b0;
        rr_sum[3]  = 4'd1;  rr_cout[3] = 1'b1;

        // Reset state; requests present but must not be granted
        reset      = 1'b1;
        req_valid  = 4'b1111;
        req_a      = 16'h0000;
        req_b      = 16'h0000;
        req_cin    = 4'b0000;
        resp_ready = 1'b1;
        #3;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(resp_valid), 32'h0);
        chk("rst_id", 32'(resp_id), 32'h0);
        chk("rst_sum", 32'(resp_sum), 32'h0);
        @(negedge clock);
        reset     = 1'b0;
        req_valid = 4'b0000;
        #1;
        chk("idle_ready", 32'(req_ready), 32'h0);
        chk("idle_add_a", 32'(add_a), 32'h0);

        // Single request on requester 0: 6+5
        @(negedge clock);
        req_valid = 4'b0001;
        req_a     = 16'h0006;
        req_b     = 16'h0005;
        req_cin   = 4'b0000;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_add_a", 32'(add_a), 32'h6);
        chk("t1_add_b", 32'(add_b), 32'h5);
        @(posedge clock); #1;
        chk("t1_valid", 32'(resp_valid), 32'h1);
        chk("t1_id", 32'(resp_id), 32'h0);
        chk("t1_sum", 32'(resp_sum), 32'd11);
        chk("t1_cout", 32'(resp_cout), 32'h0);
        @(negedge clock);
        req_valid = 4'b0000;
        @(posedge clock); #1;
        chk("t1_drain", 32'(resp_valid), 32'h0);

        // Overflow on requester 2: 15+1+1
        @(negedge clock);
        req_valid = 4'b0100;
        req_a     = 16'h0F00;
        req_b     = 16'h0100;
        req_cin   = 4'b0100;
        #1;
        chk("t2_ready", 32'(req_ready), 32'h4);
        chk("t2_add_cin", 32'(add_cin), 32'h1);
        @(posedge clock); #1;
        chk("t2_id", 32'(resp_id), 32'h2);
        chk("t2_sum", 32'(resp_sum), 32'h1);
        chk("t2_cout", 32'(resp_cout), 32'h1);
        @(negedge clock);
        req_valid = 4'b0000;
        @(posedge clock); #1;
        chk("t2_drain", 32'(resp_valid), 32'h0);

        // Pointer skip and wrap: grant 3 alone (ptr -> 0), then 3 and 1
        @(negedge clock);
        req_valid = 4'b1000;
        req_a     = 16'h2040;
        req_b     = 16'h3040;
        req_cin   = 4'b0000;
        #1;
        chk("t5_g3_ready", 32'(req_ready), 32'h8);
        @(posedge clock); #1;
        chk("t5_g3_id", 32'(resp_id), 32'h3);
        chk("t5_g3_sum", 32'(resp_sum), 32'h5);
        @(negedge clock);
        req_valid = 4'b1010;
        #1;
        chk("t5_wrap_ready", 32'(req_ready), 32'h2);
        @(posedge clock); #1;
        chk("t5_wrap_id", 32'(resp_id), 32'h1);
        chk("t5_wrap_sum", 32'(resp_sum), 32'h8);
        @(negedge clock);
        #1;
        chk("t5_skip_ready", 32'(req_ready), 32'h8);
        @(posedge clock); #1;
        chk("t5_skip_id", 32'(resp_id), 32'h3);
        chk("t5_skip_valid", 32'(resp_valid), 32'h1);

        // Round-robin with all four valid, ptr now 0
        @(negedge clock);
        req_valid = 4'b1111;
        req_a     = 16'h7531;
        req_b     = 16'h9642;
        req_cin   = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            if (k != 0) @(negedge clock);
            #1;
            chk($sformatf("t3_ready_%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
            @(posedge clock); #1;
            chk($sformatf("t3_id_%0d", k), 32'(resp_id), 32'(k % 4));
            chk($sformatf("t3_sum_%0d", k), 32'(resp_sum), 32'(rr_sum[k % 4]));
            chk($sformatf("t3_cout_%0d", k), 32'(resp_cout), 32'(rr_cout[k % 4]));
        end

        // Back-pressure: requester 1 pending with new operands 9+3+1
        @(negedge clock);
        resp_ready = 1'b0;
        req_valid  = 4'b0010;
        req_a      = 16'h7591;
        req_b      = 16'h9632;
        req_cin    = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clock);
            #1;
            chk($sformatf("t4_blocked_%0d", k), 32'(req_ready), 32'h0);
            @(posedge clock); #1;
            chk($sformatf("t4_hold_valid_%0d", k), 32'(resp_valid), 32'h1);
            chk($sformatf("t4_hold_id_%0d", k), 32'(resp_id), 32'h1);
            chk($sformatf("t4_hold_sum_%0d", k), 32'(resp_sum), 32'h8);
        end
        @(negedge clock);
        resp_ready = 1'b1;
        #1;
        chk("t4_release_ready", 32'(req_ready), 32'h2);
        @(posedge clock); #1;
        chk("t4_new_id", 32'(resp_id), 32'h1);
        chk("t4_new_sum", 32'(resp_sum), 32'd13);
        chk("t4_new_valid", 32'(resp_valid), 32'h1);
        @(negedge clock);
        req_valid = 4'b0000;
        @(posedge clock); #1;
        chk("t4_drain", 32'(resp_valid), 32'h0);

        // Async reset mid-stream; ptr is 2 here, so requester 2 wins first
        @(negedge clock);
        req_valid = 4'b0100;
        @(posedge clock); #1;
        chk("t6_pre_id", 32'(resp_id), 32'h2);
        chk("t6_pre_sum", 32'(resp_sum), 32'd11);
        @(negedge clock);
        req_valid  = 4'b0101;
        resp_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(resp_valid), 32'h0);
        chk("t6_rst_ready", 32'(req_ready), 32'h0);
        chk("t6_rst_sum", 32'(resp_sum), 32'h0);
        @(negedge clock);
        reset      = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk("t6_restart_ready", 32'(req_ready), 32'h1);
        @(posedge clock); #1;
        chk("t6_restart_id", 32'(resp_id), 32'h0);
        chk("t6_restart_sum", 32'(resp_sum), 32'h3);
        chk("t6_restart_valid", 32'(resp_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
